// File: rtl/fsk_demod_s2p_pkg.sv
// Shared definitions for the FSK receiver; the transmit modulator uses the same
// defaults so both ends agree on bit timing and tone discrimination.
package fsk_demod_s2p_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } demod_state_t;

    localparam int FRAME_BITS         = 16;
    localparam int DEF_BIT_CYCLES     = 64;
    localparam int DEF_EDGE_THRESH    = 6;
    localparam int DEF_IDLE_TIMEOUT   = 32;

endpackage

// File: rtl/fsk_demod_s2p_edge_sync.sv
// Two-flop synchroniser for the asynchronous FSK line followed by a registered
// rising-edge pulse.
module fsk_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic fsk_in,
    output logic edge_p
);

    logic       sync_q;
    logic       sync_qq;
    logic [1:0] prime;

    // prime masks the false edge seen when the line is already high at reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= 1'b0;
            sync_qq <= 1'b0;
            prime   <= 2'b00;
            edge_p  <= 1'b0;
        end else begin
            sync_q  <= fsk_in;
            sync_qq <= sync_q;
            prime   <= {prime[0], 1'b1};
            edge_p  <= sync_q & ~sync_qq & prime[1];
        end
    end

endmodule

// File: rtl/fsk_demod_s2p.sv
// FSK receiver: counts rising edges per bit window, decides each bit against a
// threshold and assembles an MSB-first codeword with a one-cycle valid strobe.
module fsk_demod_s2p
    import fsk_demod_s2p_pkg::*;
#(
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int EDGE_THRESH  = DEF_EDGE_THRESH,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fsk_in,
    output logic [FRAME_BITS-1:0] code_out,
    output logic                  code_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int WIN_W = $clog2(BIT_CYCLES + 1);
    localparam int GAP_W = $clog2(IDLE_TIMEOUT + 1);

    demod_state_t          state;
    demod_state_t          state_nxt;
    logic                  edge_p;
    logic [WIN_W-1:0]      win_cnt;
    logic [WIN_W-1:0]      win_inc;
    logic [3:0]            edge_cnt;
    logic [4:0]            bit_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [GAP_W-1:0]      gap_nxt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  win_close;
    logic                  timeout;
    logic                  last_bit;

    fsk_edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .fsk_in (fsk_in),
        .edge_p (edge_p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout outranks a coincident window close so a dead line never completes a frame
    always_comb begin
        state_nxt = state;
        win_inc   = win_cnt + 1'b1;
        gap_nxt   = gap_cnt;
        win_close = 1'b0;
        timeout   = 1'b0;
        last_bit  = (bit_cnt == 5'(FRAME_BITS - 1));

        if (edge_p) begin
            gap_nxt = '0;
        end else if (gap_cnt != GAP_W'(IDLE_TIMEOUT)) begin
            gap_nxt = gap_cnt + 1'b1;
        end

        case (state)
            HUNT: begin
                if (edge_p) begin
                    state_nxt = RECV;
                end
            end
            RECV: begin
                win_close = (win_inc == WIN_W'(BIT_CYCLES));
                timeout   = (gap_nxt == GAP_W'(IDLE_TIMEOUT));
                if (timeout) begin
                    state_nxt = HUNT;
                end else if (win_close && last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = HUNT;
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt    <= '0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shift_reg  <= '0;
            code_out   <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= (state == DONE);
            frame_err  <= timeout;
            case (state)
                HUNT: begin
                    if (edge_p) begin
                        win_cnt   <= WIN_W'(1);
                        edge_cnt  <= 4'd1;
                        bit_cnt   <= '0;
                        gap_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                RECV: begin
                    if (timeout) begin
                        win_cnt   <= '0;
                        edge_cnt  <= '0;
                        bit_cnt   <= '0;
                        gap_cnt   <= '0;
                        shift_reg <= '0;
                    end else begin
                        gap_cnt <= gap_nxt;
                        if (win_close) begin
                            // An edge on the closing cycle belongs to the next window
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], (edge_cnt >= 4'(EDGE_THRESH))};
                            win_cnt   <= '0;
                            bit_cnt   <= bit_cnt + 1'b1;
                            edge_cnt  <= edge_p ? 4'd1 : 4'd0;
                        end else begin
                            win_cnt <= win_inc;
                            if (edge_p && edge_cnt != 4'd15) begin
                                edge_cnt <= edge_cnt + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    code_out <= shift_reg;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_fsk_demod_s2p.sv
// Directed bench for fsk_demod_s2p: table-driven frames plus abort, reset and
// idle-line sequences, all with hand-derived expected codewords and timings.
module tb_fsk_demod_s2p;

    // Line rise to code_valid: 2 synchroniser/edge stages plus 1025 cycles from edge_p
    localparam int FRAME_LAT = 1027;
    // Line rise of the last edge to frame_err: 3 pipeline cycles plus 32 idle cycles
    localparam int ERR_LAT   = 35;

    typedef struct {
        logic [15:0] word;
        int          mode;
        logic [15:0] expect_code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fsk_in;
    logic [15:0] code_out;
    logic        code_valid;
    logic        frame_err;
    logic        busy;

    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt_dut = 0;
    int busy_cnt = 0;
    int errors = 0;
    int checks = 0;

    vec_t vecs[4];

    fsk_demod_s2p dut (
        .clk        (clk),
        .rst        (rst),
        .fsk_in     (fsk_in),
        .code_out   (code_out),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (code_valid) valid_cnt = valid_cnt + 1;
        if (frame_err) err_cnt_dut = err_cnt_dut + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // mode 0: nominal tones, 1: 6 edges/window, 2: 5 edges/window
    function automatic logic level(input logic b, input int mode, input int c);
        case (mode)
            1:       return (c < 60) && ((c % 10) < 5);
            2:       return (c < 60) && ((c % 12) < 6);
            default: return b ? ((c % 8) < 4) : ((c % 16) < 8);
        endcase
    endfunction

    task automatic apply_stimulus(input logic [15:0] w, input int nbits, input int mode);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < 64; c++) begin
                fsk_in = level(w[15-i], mode, c);
                @(posedge clk);
                #1;
            end
        end
        fsk_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output logic seen, output int at);
        seen = 1'b0;
        at   = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (code_valid) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_err(input int budget, output logic seen, output int at);
        seen = 1'b0;
        at   = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (frame_err) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no summary expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;
        int   at;
        int   c0;
        int   v0;
        int   e0;
        int   b0;

        vecs[0] = '{word: 16'hA5C3, mode: 0, expect_code: 16'hA5C3};
        vecs[1] = '{word: 16'h0000, mode: 1, expect_code: 16'hFFFF};
        vecs[2] = '{word: 16'hFFFF, mode: 2, expect_code: 16'h0000};
        vecs[3] = '{word: 16'h8001, mode: 0, expect_code: 16'h8001};

        rst    = 1'b0;
        fsk_in = 1'b0;
        idle(4);
        check_output("reset_code_out", code_out, 16'h0000);
        check_output("reset_code_valid", code_valid, 1'b0);
        check_output("reset_frame_err", frame_err, 1'b0);
        check_output("reset_busy", busy, 1'b0);
        rst = 1'b1;
        idle(10);

        for (int i = 0; i < 4; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt_dut;
            c0 = cyc;
            apply_stimulus(vecs[i].word, 16, vecs[i].mode);
            wait_valid(20, seen, at);
            check_output($sformatf("vec%0d_valid_seen", i), seen, 1'b1);
            check_output($sformatf("vec%0d_latency", i), at - c0, FRAME_LAT);
            idle(80);
            check_output($sformatf("vec%0d_code_out", i), code_out, vecs[i].expect_code);
            check_output($sformatf("vec%0d_valid_count", i), valid_cnt - v0, 1);
            check_output($sformatf("vec%0d_frame_err_count", i), err_cnt_dut - e0, 0);
        end

        // Tone dies after five 1-bits; last rise is at offset 56 of bit 4
        v0 = valid_cnt;
        e0 = err_cnt_dut;
        c0 = cyc;
        apply_stimulus(16'hF800, 5, 0);
        wait_err(60, seen, at);
        check_output("abort_err_seen", seen, 1'b1);
        check_output("abort_err_latency", at - c0, 4 * 64 + 56 + ERR_LAT);
        idle(5);
        check_output("abort_busy", busy, 1'b0);
        check_output("abort_err_count", err_cnt_dut - e0, 1);
        check_output("abort_valid_count", valid_cnt - v0, 0);
        check_output("abort_code_kept", code_out, 16'h8001);
        idle(80);
        v0 = valid_cnt;
        apply_stimulus(16'h1234, 16, 0);
        wait_valid(20, seen, at);
        idle(10);
        check_output("after_abort_code_out", code_out, 16'h1234);
        check_output("after_abort_valid_count", valid_cnt - v0, 1);
        check_output("after_abort_err_count", err_cnt_dut - e0, 1);

        // Reset during bit 9 of a frame
        v0 = valid_cnt;
        e0 = err_cnt_dut;
        apply_stimulus(16'hBEEF, 9, 0);
        rst = 1'b0;
        #1;
        check_output("midreset_code_out", code_out, 16'h0000);
        check_output("midreset_busy", busy, 1'b0);
        idle(3);
        rst = 1'b1;
        idle(100);
        check_output("midreset_valid_count", valid_cnt - v0, 0);
        check_output("midreset_err_count", err_cnt_dut - e0, 0);
        apply_stimulus(16'h0F0F, 16, 0);
        wait_valid(20, seen, at);
        idle(10);
        check_output("midreset_new_code_out", code_out, 16'h0F0F);
        check_output("midreset_new_valid_count", valid_cnt - v0, 1);

        // Back-to-back frames with 64 idle cycles between them
        v0 = valid_cnt;
        e0 = err_cnt_dut;
        apply_stimulus(16'hFFFF, 16, 0);
        idle(64);
        check_output("b2b_first_code_out", code_out, 16'hFFFF);
        apply_stimulus(16'h0000, 16, 0);
        wait_valid(20, seen, at);
        check_output("b2b_second_valid_seen", seen, 1'b1);
        idle(10);
        check_output("b2b_second_code_out", code_out, 16'h0000);
        check_output("b2b_valid_count", valid_cnt - v0, 2);
        check_output("b2b_err_count", err_cnt_dut - e0, 0);

        // Line already high through reset and held there
        rst    = 1'b0;
        fsk_in = 1'b1;
        idle(3);
        v0 = valid_cnt;
        e0 = err_cnt_dut;
        b0 = busy_cnt;
        rst = 1'b1;
        idle(5000);
        check_output("idle_high_busy_cycles", busy_cnt - b0, 0);
        check_output("idle_high_valid_count", valid_cnt - v0, 0);
        check_output("idle_high_err_count", err_cnt_dut - e0, 0);
        fsk_in = 1'b0;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
